// File: rtl/atmos_light_est.sv
// Tracks the brightest dark-channel pixel per frame and publishes its RGB (clamped) as atmospheric light A.
// Latency: 2 clk from raw vsync fall to atmos_valid; no backpressure: the pixel stream never stalls, outputs hold between pulses.
module atmos_light_est #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int A_MAX  = 220,
    parameter int A_INIT = 255,
    localparam int XW = $clog2(IMG_W),
    localparam int YW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          per_frame_vsync,
    input  logic          per_frame_href,
    input  logic          per_frame_clken,
    input  logic [7:0]    per_dark,
    input  logic [23:0]   per_img,
    output logic [7:0]    atmos_r,
    output logic [7:0]    atmos_g,
    output logic [7:0]    atmos_b,
    output logic [7:0]    atmos_dark,
    output logic [XW-1:0] atmos_x,
    output logic [YW-1:0] atmos_y,
    output logic          atmos_valid
);

    logic          vsync_d;
    logic          href_d;
    logic          hist_vld;
    logic          armed;
    logic          seen;
    logic          pub_pend;
    logic [7:0]    run_max;
    logic [23:0]   cap_rgb;
    logic [XW-1:0] cap_x;
    logic [YW-1:0] cap_y;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;

    logic          vs_rise;
    logic          vs_fall;
    logic          href_fall;
    logic          acc;
    logic          take;
    logic          eff_seen;
    logic [7:0]    eff_max;
    logic [XW-1:0] eff_x;
    logic [YW-1:0] eff_y;
    logic [XW-1:0] x_inc;
    logic [YW-1:0] y_inc;

    function automatic logic [7:0] clamp8(input logic [7:0] v);
        return (v > 8'(A_MAX)) ? 8'(A_MAX) : v;
    endfunction

    // hist_vld masks the first cycle after reset, so a frame already in
    // progress does not look like a rising vsync edge.
    always_comb begin
        vs_rise   = per_frame_vsync & ~vsync_d & hist_vld;
        vs_fall   = ~per_frame_vsync & vsync_d;
        href_fall = ~per_frame_href & href_d;
        acc       = per_frame_vsync & per_frame_href & per_frame_clken;
        eff_seen  = vs_rise ? 1'b0 : seen;
        eff_max   = vs_rise ? 8'd0 : run_max;
        eff_x     = vs_rise ? '0 : x_cnt;
        eff_y     = vs_rise ? '0 : y_cnt;
        take      = acc & (~eff_seen | (per_dark > eff_max));
        x_inc     = (eff_x == XW'(IMG_W - 1)) ? eff_x : eff_x + 1'b1;
        y_inc     = (eff_y == YW'(IMG_H - 1)) ? eff_y : eff_y + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d     <= 1'b0;
            href_d      <= 1'b0;
            hist_vld    <= 1'b0;
            armed       <= 1'b0;
            seen        <= 1'b0;
            pub_pend    <= 1'b0;
            run_max     <= 8'd0;
            cap_rgb     <= 24'd0;
            cap_x       <= '0;
            cap_y       <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            atmos_r     <= 8'(A_INIT);
            atmos_g     <= 8'(A_INIT);
            atmos_b     <= 8'(A_INIT);
            atmos_dark  <= 8'd0;
            atmos_x     <= '0;
            atmos_y     <= '0;
            atmos_valid <= 1'b0;
        end else begin
            vsync_d     <= per_frame_vsync;
            href_d      <= per_frame_href;
            hist_vld    <= 1'b1;
            atmos_valid <= 1'b0;
            pub_pend    <= 1'b0;

            if (vs_rise) begin
                armed   <= 1'b1;
                seen    <= 1'b0;
                run_max <= 8'd0;
                x_cnt   <= '0;
                y_cnt   <= '0;
            end

            // Strict compare keeps the first pixel in raster order on ties.
            if (acc) begin
                if (take) begin
                    run_max <= per_dark;
                    cap_rgb <= per_img;
                    cap_x   <= eff_x;
                    cap_y   <= eff_y;
                    seen    <= 1'b1;
                end
                x_cnt <= x_inc;
            end

            if (href_fall) begin
                x_cnt <= '0;
                y_cnt <= y_inc;
            end

            if (vs_fall) begin
                pub_pend <= armed & seen;
                armed    <= 1'b0;
            end

            // Captured registers are read before any same-edge capture of a
            // back-to-back frame overwrites them.
            if (pub_pend) begin
                atmos_r     <= clamp8(cap_rgb[23:16]);
                atmos_g     <= clamp8(cap_rgb[15:8]);
                atmos_b     <= clamp8(cap_rgb[7:0]);
                atmos_dark  <= run_max;
                atmos_x     <= cap_x;
                atmos_y     <= cap_y;
                atmos_valid <= 1'b1;
            end
        end
    end

endmodule
